// File: rtl/pulse_gate_ctrl.sv
`default_nettype none
// ============================================================================
// pulse_gate_ctrl : timed gate-window sequencer for an external pulse counter
// Revision 1.0
// ============================================================================
module pulse_gate_ctrl #(
   parameter int CNT_W      = 32,
   parameter int GATE_W     = 32,
   parameter int SETTLE_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cont,
   input  logic              abort,
   input  logic [GATE_W-1:0] gate_len,
   input  logic [CNT_W-1:0]  cnt_in,
   output logic              cnt_clr,
   output logic              cnt_en,
   output logic              busy,
   output logic [CNT_W-1:0]  result,
   output logic              result_valid,
   output logic              ovf,
   output logic [7:0]        seq
);

   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_GATE   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_LATCH  = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [GATE_W-1:0] gate_len_q;
   logic [GATE_W-1:0] gate_cnt;
   logic [SET_W-1:0]  settle_cnt;
   logic              latch_fire;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (!abort && start && (gate_len != '0)) state_nxt = ST_CLEAR;
         end
         ST_CLEAR: begin
            state_nxt = abort ? ST_IDLE : ST_GATE;
         end
         ST_GATE: begin
            if (abort)                         state_nxt = ST_IDLE;
            else if (gate_cnt == GATE_W'(1))   state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (abort)                         state_nxt = ST_IDLE;
            else if (settle_cnt == SET_LAST)   state_nxt = ST_LATCH;
         end
         ST_LATCH: begin
            if (!abort && cont && (gate_len != '0)) state_nxt = ST_CLEAR;
            else                                    state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // abort in LATCH suppresses the capture entirely
   assign latch_fire = (state == ST_LATCH) && !abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         gate_len_q   <= '0;
         gate_cnt     <= '0;
         settle_cnt   <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         ovf          <= 1'b0;
         seq          <= 8'd0;
      end else begin
         state <= state_nxt;
         // CLEAR is entered only from IDLE or LATCH, both capture points
         if (state_nxt == ST_CLEAR) gate_len_q <= gate_len;
         if (state == ST_CLEAR)     gate_cnt <= gate_len_q;
         else if (state == ST_GATE) gate_cnt <= gate_cnt - GATE_W'(1);
         settle_cnt   <= (state == ST_SETTLE) ? settle_cnt + SET_W'(1) : '0;
         result_valid <= latch_fire;
         if (latch_fire) begin
            result <= cnt_in;
            ovf    <= (cnt_in == {CNT_W{1'b1}});
            seq    <= seq + 8'd1;
         end
      end
   end

   assign cnt_clr = (state == ST_CLEAR);
   assign cnt_en  = (state == ST_GATE);
   assign busy    = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pulse_gate_ctrl.sv
`default_nettype none
// Testbench for pulse_gate_ctrl: timeline reference model + result scoreboard.
module tb_pulse_gate_ctrl;

   localparam int CW   = 32;
   localparam int GW   = 32;
   localparam int S    = 2;
   localparam int MAXC = 60000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          cont = 1'b0;
   logic          abort = 1'b0;
   logic [GW-1:0] gate_len = '0;
   logic [CW-1:0] cnt_in;
   logic          cnt_clr, cnt_en, busy, result_valid, ovf;
   logic [CW-1:0] result;
   logic [7:0]    seq;

   pulse_gate_ctrl #(.CNT_W(CW), .GATE_W(GW), .SETTLE_CYC(S)) dut (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
      .gate_len(gate_len), .cnt_in(cnt_in), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
      .busy(busy), .result(result), .result_valid(result_valid), .ovf(ovf), .seq(seq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // pulse_arr[c] is the input pulse present during cycle c; expected ctl is {clr,en,busy}
   bit       pulse_arr [MAXC];
   bit [2:0] exp_ctl   [MAXC];

   // saturating pulse counter that the sequencer controls
   logic [CW-1:0] clr_base = '0;
   logic [CW-1:0] env_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst)                                                   env_cnt <= '0;
      else if (cnt_clr)                                          env_cnt <= clr_base;
      else if (cnt_en && pulse_arr[cyc] && (env_cnt != '1))      env_cnt <= env_cnt + 1'b1;
   end
   assign cnt_in = env_cnt;

   typedef struct {
      int            vcyc;
      logic [CW-1:0] res;
      logic          o;
      logic [7:0]    sq;
   } exp_t;

   exp_t       sbq[$];
   exp_t       e;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] seq_m  = 8'd0;
   bit         mon_on = 1'b0;
   int         lens [300];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, expv);
      end
   endtask

   // Accepted start whose CLEAR cycle is t0: CLEAR, N gate cycles, S settle, 1 latch.
   function automatic void mark(input int t0, input int n, input int upto);
      for (int r = 1; r <= upto; r++)
         if (t0 + r - 1 < MAXC)
            exp_ctl[t0+r-1] = (r == 1) ? 3'b101 : (r <= n + 1) ? 3'b011 : 3'b001;
   endfunction

   function automatic void push_result(input int t0, input int n);
      longint s;
      exp_t   x;
      s = longint'(clr_base);
      for (int i = t0 + 1; i <= t0 + n; i++) s += longint'(pulse_arr[i]);
      if (s > 64'd4294967295) s = 64'd4294967295;
      seq_m  = seq_m + 8'd1;
      x.vcyc = t0 + n + 2 + S;
      x.res  = s[31:0];
      x.o    = (s == 64'd4294967295);
      x.sq   = seq_m;
      sbq.push_back(x);
   endfunction

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // nres back-to-back measurements using lens[]; optional abort of measurement ab_idx
   task automatic run_seq(input int nres, input int ab_idx, input int ab_rel);
      int t0, tl, n;
      start    = 1'b1;
      gate_len = lens[0];
      cont     = (nres > 1);
      t0       = cyc + 1;
      for (int k = 0; k < nres; k++) begin
         n  = lens[k];
         tl = t0 + n + 1 + S;
         if (k == ab_idx) mark(t0, n, ab_rel);
         else begin
            mark(t0, n, n + 2 + S);
            push_result(t0, n);
         end
         wait_cyc(t0);
         start    = 1'b0;
         gate_len = $urandom_range(0, 63);
         if (k == ab_idx) begin
            wait_cyc(t0 + ab_rel - 1);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            cont  = 1'b0;
            return;
         end
         wait_cyc(tl - 1);
         if (k + 1 < nres) begin
            gate_len = lens[k+1];
            cont     = 1'b1;
         end else begin
            cont = 1'b0;
         end
         t0 = tl + 1;
      end
      wait_cyc(t0);
   endtask

   always @(negedge clk) begin
      if (cyc >= MAXC - 2) begin
         $display("FAIL watchdog: cycle %0d reached limit %0d", cyc, MAXC - 2);
         $fatal(1, "cycle budget exhausted");
      end
      if (mon_on && !rst) begin
         chk("ctl_clr_en_busy", {cnt_clr, cnt_en, busy}, exp_ctl[cyc]);
         if (result_valid) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: result_valid at cycle %0d, expected none", cyc);
            end else begin
               e = sbq.pop_front();
               chk("rv_cycle", cyc, e.vcyc);
               chk("result", result, e.res);
               chk("ovf", ovf, e.o);
               chk("seq", seq, e.sq);
            end
         end
      end
   end

   initial begin
      int t0, t1, kind, nres, ab_idx, ab_rel;
      for (int i = 0; i < MAXC; i++)
         pulse_arr[i] = (i < 3000) ? (i % 10 == 0) : ($urandom_range(0, 1) == 1);

      repeat (3) @(negedge clk);
      chk("rst_cnt_clr", cnt_clr, 0);
      chk("rst_cnt_en", cnt_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", result, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_seq", seq, 0);
      rst    = 1'b0;
      mon_on = 1'b1;
      repeat (2) @(negedge clk);

      // single shot, N=100, one pulse every 10 cycles -> 10
      lens[0] = 100;
      run_seq(1, -1, 0);
      // continuous, three results of N=20
      for (int k = 0; k < 3; k++) lens[k] = 20;
      run_seq(3, -1, 0);
      // abort in first SETTLE cycle
      lens[0] = 50;
      run_seq(1, 0, 52);
      // start with gate_len=0 is ignored
      start = 1'b1; gate_len = '0;
      repeat (3) @(negedge clk);
      start = 1'b0;
      // abort beats start in IDLE
      start = 1'b1; gate_len = 7; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      @(negedge clk);

      // asynchronous reset in the middle of a 100-cycle gate
      t0 = cyc + 1;
      start = 1'b1; gate_len = 100;
      mark(t0, 100, 51);
      wait_cyc(t0);
      start = 1'b0;
      wait_cyc(t0 + 50);
      #1 rst = 1'b1;
      #1;
      chk("arst_cnt_en", cnt_en, 0);
      chk("arst_busy", busy, 0);
      chk("arst_cnt_clr", cnt_clr, 0);
      chk("arst_result", result, 0);
      chk("arst_seq", seq, 0);
      chk("arst_result_valid", result_valid, 0);
      seq_m = 8'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // saturated counter -> ovf, then a normal result clears it
      clr_base = 32'hFFFF_FFFC;
      lens[0]  = 60;
      run_seq(1, -1, 0);
      clr_base = '0;
      lens[0]  = 33;
      run_seq(1, -1, 0);

      // start held through a measurement; gate_len change mid-GATE takes effect next time
      t0 = cyc + 1;
      start = 1'b1; gate_len = 30;
      mark(t0, 30, 32 + S);
      push_result(t0, 30);
      t1 = t0 + 30 + 3 + S;
      mark(t1, 5, 7 + S);
      push_result(t1, 5);
      wait_cyc(t0 + 15);
      gate_len = 5;
      wait_cyc(t1);
      start = 1'b0;
      wait_cyc(t1 + 5 + 2 + S);

      // randomized traffic
      for (int it = 0; it < 150; it++) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            gate_len = '0; start = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start = 1'b0;
         end else if (kind == 1) begin
            start = 1'b1; gate_len = $urandom_range(1, 50); abort = 1'b1;
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
         end else begin
            nres = $urandom_range(1, 3);
            for (int k = 0; k < nres; k++) lens[k] = $urandom_range(1, 40);
            case ($urandom_range(0, 5))
               0:       clr_base = 32'hFFFF_FFFF - $urandom_range(0, 25);
               1:       clr_base = $urandom;
               default: clr_base = '0;
            endcase
            ab_idx = -1;
            ab_rel = 0;
            if ($urandom_range(0, 3) == 0) begin
               ab_idx = $urandom_range(0, nres - 1);
               ab_rel = $urandom_range(1, lens[ab_idx] + 2 + S);
            end
            run_seq(nres, ab_idx, ab_rel);
         end
      end

      // long continuous run of N=1 so seq wraps past 255
      clr_base = '0;
      for (int k = 0; k < 260; k++) lens[k] = 1;
      run_seq(260, -1, 0);

      repeat (10) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
